axi_ad9371_tx_sync_ctrl: RTL
============================

# axi_ad9371_tx_sync_ctrl

Start/stop sequencer for the AD9371 transmit datapath, clocked in the DAC domain between the common DAC register block and the four TX channels. It arms on a processor sync request and aligns the start of transmission across master/slave transceiver instances via a programmable start delay. It then releases the one-cycle data-sync pulse to the channels and gates per-channel DMA valids and output muting. It also counts DMA underflow cycles while running.

## Interface
Parameters:
- MASTER, 1: 1 = this instance generates sync and ignores dac_sync_in; 0 = slave, waits for a rising edge on dac_sync_in.
- DELAY_WIDTH, 8: width of dac_sync_delay and the internal delay counter.
- UNF_CNT_WIDTH, 16: width of dac_unf_count.

Ports:
- dac_clk  in  1  DAC-domain clock; the only clock.
- dac_rst  in  1  synchronous, active-high reset.
- dac_sync_arm  in  1  single-cycle arm request from the common register block.
- dac_sync_stop  in  1  single-cycle stop request.
- dac_sync_in  in  1  external sync level from the master instance; used when MASTER=0.
- dac_sync_delay  in  DELAY_WIDTH  start delay in dac_clk cycles; static while armed.
- dac_enable  in  4  channel enables, ordered i0, q0, i1, q1.
- dac_dunf  in  1  DMA underflow flag.
- dac_sync_out  out  1  one-cycle sync pulse to slave instances; master only, 0 when MASTER=0.
- dac_data_sync  out  1  one-cycle pulse to all channels: reset DDS phase, start data.
- dac_valid  out  4  per-channel DMA valid.
- dac_data_mute  out  1  channels drive zero while high.
- dac_armed  out  1  state is ARMED or DELAY.
- dac_running  out  1  state is RUN.
- dac_unf_count  out  UNF_CNT_WIDTH  saturating count of underflow cycles in RUN.

## Operation
- States: IDLE, ARMED, DELAY, RUN. Reset enters IDLE.
- Request priority in any state: dac_sync_stop goes to IDLE. Otherwise dac_sync_arm goes to ARMED, clears dac_unf_count and reloads nothing yet. Stop and arm in the same cycle: stop wins.
- IDLE: waits for arm.
- ARMED, master: leaves after one cycle. Transitions to DELAY, registers dac_sync_out=1 for exactly that transition cycle, and loads cnt <= dac_sync_delay.
- ARMED, slave: registers dac_sync_in_d every cycle. On edge (dac_sync_in & ~dac_sync_in_d), goes to DELAY and loads cnt. Edges outside ARMED are ignored. A sync_in held high on entry to ARMED is not an edge.
- DELAY: if cnt==0, go to RUN and register dac_data_sync=1 for one cycle; else cnt <= cnt-1. DELAY therefore lasts dac_sync_delay+1 cycles. Delay 0 gives 1 cycle; all-ones gives 2^DELAY_WIDTH cycles, with no wrap.
- RUN: dac_valid <= dac_enable, dac_data_mute <= 0. If dac_dunf=1, increment dac_unf_count, saturating at all-ones. Arm in RUN resynchronizes: back to ARMED, mute reasserted.
- Outside RUN: dac_valid <= 0, dac_data_mute <= 1, counter holds.

## Timing
- All outputs registered. Reset values: dac_data_mute=1; every other output 0; cnt=0; dac_sync_in_d=0.
- Master: arm sampled at cycle k. ARMED at k+1. dac_sync_out=1 and DELAY at k+2. dac_data_sync=1, RUN, dac_running=1 and dac_valid=dac_enable at k+3+D, where D = dac_sync_delay.
- Slave: edge sampled at cycle j. DELAY at j+1. dac_data_sync at j+2+D.
- Inter-chip skew: a master at k+2 feeds the slave edge at k+2, so the slave data_sync lands at k+4+D_s. Alignment requires D_master = D_slave + 1.
- dac_enable change in RUN reaches dac_valid one cycle later.
- Stop/arm sampled at cycle t: new state, dac_valid=0 and mute=1 all at t+1.
- Reset mid-operation: IDLE next cycle, counters cleared, no dac_data_sync pulse emitted.

## Test plan
- Master, D=3, enable=4'b1111, arm at cycle 10 -> dac_sync_out high only at 12; dac_data_sync high only at 16; dac_valid=4'hF and mute=0 from 16.
- Slave, D=0, dac_sync_in rises at cycle 20 after arm at 5 -> DELAY at 21, dac_data_sync at 22. A second sync_in edge at 30 in RUN -> no effect.
- Slave armed with dac_sync_in already high -> stays ARMED until sync_in falls and rises again.
- RUN with dac_dunf high 5 cycles -> dac_unf_count=5. UNF_CNT_WIDTH=4 with 20 cycles -> saturates at 15. Re-arm -> count 0.
- Arm and stop in the same cycle during DELAY -> IDLE next cycle, no dac_data_sync, dac_valid stays 0.
- D=255, master -> dac_data_sync exactly 256 cycles after DELAY entry. dac_rst asserted at cycle 100 of that window -> IDLE, mute=1, no pulse.

Source files
------------

// File: rtl/axi_ad9371_tx_sync_ctrl_if.sv
// Control/status bundle between the DAC common register block / DMA side
// and the TX start/stop sequencer.
interface axi_ad9371_tx_sync_ctrl_if #(
  parameter int unsigned DELAY_WIDTH   = 8,
  parameter int unsigned UNF_CNT_WIDTH = 16
);
  logic                     dac_sync_arm;
  logic                     dac_sync_stop;
  logic                     dac_sync_in;
  logic [DELAY_WIDTH-1:0]   dac_sync_delay;
  logic [3:0]               dac_enable;
  logic                     dac_dunf;
  logic                     dac_sync_out;
  logic                     dac_data_sync;
  logic [3:0]               dac_valid;
  logic                     dac_data_mute;
  logic                     dac_armed;
  logic                     dac_running;
  logic [UNF_CNT_WIDTH-1:0] dac_unf_count;

  // Requester side: register block, DMA and the sync source.
  modport master (
    output dac_sync_arm, dac_sync_stop, dac_sync_in, dac_sync_delay,
           dac_enable, dac_dunf,
    input  dac_sync_out, dac_data_sync, dac_valid, dac_data_mute,
           dac_armed, dac_running, dac_unf_count
  );

  // Sequencer side.
  modport slave (
    input  dac_sync_arm, dac_sync_stop, dac_sync_in, dac_sync_delay,
           dac_enable, dac_dunf,
    output dac_sync_out, dac_data_sync, dac_valid, dac_data_mute,
           dac_armed, dac_running, dac_unf_count
  );
endinterface

// File: rtl/axi_ad9371_tx_sync_ctrl.sv
// AD9371 TX start/stop sequencer: arm, optional slave sync wait, programmable
// start delay, one-cycle data-sync release, valid/mute gating, underflow count.
module axi_ad9371_tx_sync_ctrl #(
  parameter bit          MASTER        = 1'b1,
  parameter int unsigned DELAY_WIDTH   = 8,
  parameter int unsigned UNF_CNT_WIDTH = 16
) (
  input  logic                           dac_clk,
  input  logic                           dac_rst,
  axi_ad9371_tx_sync_ctrl_if.slave       bus
);

  localparam int unsigned DW = DELAY_WIDTH;
  localparam int unsigned UW = UNF_CNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t          state_q,     state_d;
  logic [DW-1:0]   cnt_q,       cnt_d;
  logic            sync_in_d_q, sync_in_d_d;
  logic            sync_out_q,  sync_out_d;
  logic            data_sync_q, data_sync_d;
  logic [3:0]      valid_q,     valid_d;
  logic            mute_q,      mute_d;
  logic            armed_q,     armed_d;
  logic            running_q,   running_d;
  logic [UW-1:0]   unf_q,       unf_d;
  logic            sync_edge;

  // Next-state and registered-output computation; stop outranks arm.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_in_d_d = bus.dac_sync_in;
    sync_out_d  = 1'b0;
    data_sync_d = 1'b0;
    unf_d       = unf_q;
    sync_edge   = bus.dac_sync_in & ~sync_in_d_q;

    if (bus.dac_sync_stop) begin
      state_d = IDLE;
    end else if (bus.dac_sync_arm) begin
      state_d = ARMED;
      unf_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          // Master starts immediately; slave waits for a fresh sync_in edge.
          if ((MASTER == 1'b1) || sync_edge) begin
            state_d    = DELAY;
            cnt_d      = bus.dac_sync_delay;
            sync_out_d = MASTER;
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d     = RUN;
            data_sync_d = 1'b1;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        RUN: begin
          if (bus.dac_dunf && (unf_q != '1)) begin
            unf_d = unf_q + UW'(1);
          end
        end
        default: begin
        end
      endcase
    end

    valid_d   = (state_d == RUN) ? bus.dac_enable : 4'h0;
    mute_d    = (state_d != RUN);
    armed_d   = (state_d == ARMED) || (state_d == DELAY);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync_in_d_q <= 1'b0;
      sync_out_q  <= 1'b0;
      data_sync_q <= 1'b0;
      valid_q     <= 4'h0;
      mute_q      <= 1'b1;
      armed_q     <= 1'b0;
      running_q   <= 1'b0;
      unf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_in_d_q <= sync_in_d_d;
      sync_out_q  <= sync_out_d;
      data_sync_q <= data_sync_d;
      valid_q     <= valid_d;
      mute_q      <= mute_d;
      armed_q     <= armed_d;
      running_q   <= running_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.dac_sync_out  = sync_out_q;
  assign bus.dac_data_sync = data_sync_q;
  assign bus.dac_valid     = valid_q;
  assign bus.dac_data_mute = mute_q;
  assign bus.dac_armed     = armed_q;
  assign bus.dac_running   = running_q;
  assign bus.dac_unf_count = unf_q;

endmodule
